// File: rtl/cic_pkg.sv
// Shared constants and helpers for the single-channel CIC decimator chain.
package cic_pkg;

    localparam int CIC_DW    = 22;  // integrator accumulator / comb width
    localparam int CIC_IN_W  = 11;  // raw input width feeding the integrator
    localparam int CIC_R_DEF = 8;
    localparam int CIC_M_DEF = 1;

    // Width of a counter that walks 0..r-1, never narrower than one bit.
    function automatic int phase_w(input int r);
        return (r <= 2) ? 1 : $clog2(r);
    endfunction

endpackage

// File: rtl/cic_decim_comb_if.sv
// Sample-strobe input and decimated-output bundle of the decimate-and-comb stage.
interface cic_decim_comb_if
    import cic_pkg::*;
#(
    parameter int DW = CIC_DW,
    parameter int PW = phase_w(CIC_R_DEF)
);

    logic                 en_i;
    logic signed [DW-1:0] data_i;
    logic                 valid_o;
    logic signed [DW-1:0] data_o;
    logic [PW-1:0]        phase_o;

    modport master (output en_i, data_i, input valid_o, data_o, phase_o);
    modport slave  (input en_i, data_i, output valid_o, data_o, phase_o);

endinterface

// File: rtl/comb_delay_line.sv
// M-deep shift register of decimated samples; tap_o presents x[k-M].
module comb_delay_line #(
    parameter int DW = 22,
    parameter int M  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 shift_i,
    input  logic signed [DW-1:0] din_i,
    output logic signed [DW-1:0] tap_o
);

    logic signed [DW-1:0] dly_q [M];
    logic signed [DW-1:0] dly_d [M];

    always_comb begin
        dly_d = dly_q;
        if (shift_i) begin
            dly_d[0] = din_i;
            for (int i = 1; i < M; i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end
    end

    // NOTE: this array is only M words of flops, so it is cleared on reset;
    // a freshly primed comb must never see stale history.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < M; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            dly_q <= dly_d;
        end
    end

    assign tap_o = dly_q[M-1];

endmodule

// File: rtl/cic_decim_comb.sv
// Keeps every R-th strobed integrator sample and emits x[k] - x[k-M] (mod 2^DW).
module cic_decim_comb
    import cic_pkg::*;
#(
    parameter int DW = CIC_DW,
    parameter int R  = CIC_R_DEF,
    parameter int M  = CIC_M_DEF
) (
    input logic            clk_i,
    input logic            rst_i,
    cic_decim_comb_if.slave bus
);

    localparam int            PW   = phase_w(R);
    localparam logic [PW-1:0] LAST = PW'(R - 1);

    logic [PW-1:0]        cnt_q, cnt_d;
    logic [1:0]           prime_q, prime_d;
    logic                 valid_q, valid_d;
    logic signed [DW-1:0] data_q, data_d;
    logic signed [DW-1:0] tap;
    logic                 capture;
    logic                 primed;

    assign capture = bus.en_i && (cnt_q == LAST);
    assign primed  = (prime_q == 2'(M));

    // NOTE: every signal gets its hold value before any branch, so no path
    // through this block can infer a latch.
    always_comb begin
        cnt_d   = cnt_q;
        prime_d = prime_q;
        valid_d = 1'b0;
        data_d  = data_q;
        if (bus.en_i) begin
            cnt_d = capture ? '0 : cnt_q + 1'b1;
        end
        if (capture) begin
            if (primed) begin
                valid_d = 1'b1;
                // Plain wrapping subtraction: integrator overflow cancels here.
                data_d  = bus.data_i - tap;
            end else begin
                prime_d = prime_q + 2'd1;
            end
        end
    end

    // NOTE: state flops take non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            prime_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            prime_q <= prime_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    comb_delay_line #(
        .DW (DW),
        .M  (M)
    ) u_delay (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .shift_i (capture),
        .din_i   (bus.data_i),
        .tap_o   (tap)
    );

    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.phase_o = cnt_q;

endmodule

// File: tb/tb_cic_decim_comb.sv
// Randomized and directed bench for cic_decim_comb (R=8/M=1 and R=4/M=2 in parallel).
module tb_cic_decim_comb;
    import cic_pkg::*;

    localparam int DW = 22;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cic_decim_comb_if #(.DW(DW), .PW(3)) if_a ();
    cic_decim_comb_if #(.DW(DW), .PW(2)) if_b ();

    cic_decim_comb #(.DW(DW), .R(8), .M(1)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if_a.slave)
    );

    cic_decim_comb #(.DW(DW), .R(4), .M(2)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if_b.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: count accepted samples, keep the list of captured samples.
    int            r_of [2] = '{8, 4};
    int            m_of [2] = '{1, 2};
    int            n_acc [2];
    logic [DW-1:0] caps [2][$];
    logic          exp_v [2];
    logic [DW-1:0] exp_d [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 2; i++) begin
            n_acc[i] = 0;
            caps[i].delete();
            exp_v[i] = 1'b0;
            exp_d[i] = '0;
        end
    endfunction

    function automatic void model_step(input logic en, input logic [DW-1:0] d);
        for (int i = 0; i < 2; i++) begin
            exp_v[i] = 1'b0;
            if (en) begin
                n_acc[i]++;
                if (n_acc[i] % r_of[i] == 0) begin
                    caps[i].push_back(d);
                    if (caps[i].size() > m_of[i]) begin
                        exp_v[i] = 1'b1;
                        exp_d[i] = d - caps[i][caps[i].size() - 1 - m_of[i]];
                        caps[i].pop_front();
                    end
                end
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_a_valid"}, 32'(if_a.valid_o), 32'(exp_v[0]));
        check({tag, "_a_data"},  32'($unsigned(if_a.data_o)), 32'(exp_d[0]));
        check({tag, "_a_phase"}, 32'(if_a.phase_o), 32'(n_acc[0] % 8));
        check({tag, "_b_valid"}, 32'(if_b.valid_o), 32'(exp_v[1]));
        check({tag, "_b_data"},  32'($unsigned(if_b.data_o)), 32'(exp_d[1]));
        check({tag, "_b_phase"}, 32'(if_b.phase_o), 32'(n_acc[1] % 4));
    endtask

    task automatic drive(input logic en, input logic [DW-1:0] d);
        if_a.en_i   = en;
        if_a.data_i = d;
        if_b.en_i   = en;
        if_b.data_i = d;
    endtask

    task automatic step(input logic en, input logic [DW-1:0] d, input string tag);
        @(negedge clk);
        drive(en, d);
        @(posedge clk);
        #1;
        model_step(en, d);
        check_outputs(tag);
    endtask

    // Reset is asserted away from the edge and checked before any clock arrives.
    task automatic do_reset(input int cycles, input string tag);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, '0);
        #1;
        model_clear();
        check_outputs(tag);
        repeat (cycles) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    int seq [4] = '{10, 30, 70, 150};

    initial begin
        int            val;
        int            nvalid;
        logic [DW-1:0] d;
        logic          en;
        bit            reached;

        drive(1'b0, '0);
        model_clear();
        do_reset(2, "por");

        // Ramp, strobe every cycle
        for (int k = 1; k <= 40; k++) step(1'b1, DW'(k), "ramp");

        // Ramp advancing only on every third cycle
        do_reset(1, "rst_gap");
        val = 0;
        for (int k = 0; k < 96; k++) begin
            en = (k % 3 == 2);
            if (en) val++;
            step(en, DW'(val), "gap");
        end

        // Captured values 0x1FFFFC then 0x200004 straddle the signed limit
        do_reset(1, "rst_wrap");
        for (int k = 0; k < 16; k++) step(1'b1, DW'(32'h1FFFF5 + k), "wrap");
        check("wrap_data_is_8", 32'($unsigned(if_a.data_o)), 32'd8);

        // Every fourth sample carries 10, 30, 70, 150 for the R=4/M=2 instance
        do_reset(1, "rst_m2");
        for (int j = 0; j < 16; j++) begin
            d = (j % 4 == 3) ? DW'(seq[j/4]) : DW'($urandom);
            step(1'b1, d, "m2");
        end
        check("m2_last_valid", 32'(if_b.valid_o), 32'd1);
        check("m2_last_data", 32'($unsigned(if_b.data_o)), 32'd120);

        // Reset in the middle of a run, at phase 5 after outputs have appeared
        do_reset(1, "rst_pre_mid");
        nvalid  = 0;
        reached = 1'b0;
        for (int k = 0; k < 100 && !reached; k++) begin
            step(1'b1, DW'($urandom), "pre_mid");
            if (if_a.valid_o) nvalid++;
            if (nvalid >= 2 && n_acc[0] % 8 == 5) reached = 1'b1;
        end
        check("mid_reset_reached", 32'(reached), 32'd1);
        do_reset(2, "mid_reset");
        nvalid = 0;
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, DW'(k * 3), "post_mid");
            if (if_a.valid_o) nvalid++;
        end
        check("post_mid_valid_count", 32'(nvalid), 32'd1);

        // Constant input cancels to zero
        do_reset(1, "rst_const");
        nvalid = 0;
        for (int k = 0; k < 80; k++) begin
            step(1'b1, DW'(24'h000123), "const");
            if (if_a.valid_o) nvalid++;
        end
        check("const_valid_count", 32'(nvalid), 32'd9);

        // Random strobes and data, including full-range wrapping values
        do_reset(1, "rst_rand");
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

endmodule
